// File: rtl/riscv_gpio_ctrl.sv
// riscv_gpio_ctrl: memory-mapped GPIO with direction, synchronised inputs, set/clear and edge interrupts
module riscv_gpio_ctrl #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bus_req,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARMED = AW'(SYNC_STAGES + 1);
  state_t state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] en, mode, status, prev, data_in, wd, rsel, edge_set, w1c;
  logic [AW-1:0] arm;
  logic hit, wr, unused_ok;
  assign data_in = sync[SYNC_STAGES-1];
  assign wd = bus_wdata[WIDTH-1:0];
  assign hit = state == IDLE && bus_req;
  assign wr = hit && bus_we;
  // edges are masked until the synchroniser has flushed its reset contents
  assign edge_set = arm == ARMED ? (mode & data_in & ~prev) | (~mode & ~data_in & prev) : '0;
  assign w1c = wr && bus_addr == 3'd5 ? wd : '0;
  assign irq = |(status & en);
  assign unused_ok = &{1'b0, bus_wdata};
  always_comb
    rsel = bus_addr == 3'd0 ? gpio_out :
           bus_addr == 3'd1 ? gpio_oe :
           bus_addr == 3'd2 ? data_in :
           bus_addr == 3'd3 ? en :
           bus_addr == 3'd4 ? mode :
           bus_addr == 3'd5 ? status : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      prev <= '0;
      arm <= '0;
      status <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], gpio_in};
      prev <= data_in;
      arm <= arm == ARMED ? arm : arm + 1'b1;
      status <= (status & ~w1c) | edge_set;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bus_ack <= 1'b0;
      bus_rdata <= '0;
      gpio_out <= OUT_RESET;
      gpio_oe <= '0;
      en <= '0;
      mode <= '0;
    end else begin
      state <= hit ? ACK : state == ACK ? WAIT : IDLE;
      bus_ack <= hit;
      bus_rdata <= hit && !bus_we ? 32'(rsel) : '0;
      if (wr) begin
        gpio_out <= bus_addr == 3'd0 ? wd :
                    bus_addr == 3'd6 ? gpio_out | wd :
                    bus_addr == 3'd7 ? gpio_out & ~wd : gpio_out;
        gpio_oe <= bus_addr == 3'd1 ? wd : gpio_oe;
        en <= bus_addr == 3'd3 ? wd : en;
        mode <= bus_addr == 3'd4 ? wd : mode;
      end
    end
endmodule

// File: tb/tb_riscv_gpio_ctrl.sv
// tb_riscv_gpio_ctrl: directed and random checks of riscv_gpio_ctrl against a pin-history model
module tb_riscv_gpio_ctrl;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0, reset_n = 0, bus_req = 0, bus_we = 0;
  logic [2:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic bus_ack, irq;
  logic [W-1:0] gpio_in = '0, gpio_out, gpio_oe;
  int tests = 0, fails = 0, k = 0;
  logic [W-1:0] m_out = '0, m_dir = '0, m_en = '0, m_mode = '0, m_status = '0;
  logic [W-1:0] hist[$];
  logic [31:0] r;

  riscv_gpio_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pin value seen at the i-th clock edge after reset release (chain holds 0 before that)
  function automatic logic [W-1:0] g(input int i);
    return (i >= 1 && i <= hist.size()) ? hist[i-1] : '0;
  endfunction

  function automatic logic [W-1:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return m_out;
      3'd1: return m_dir;
      3'd2: return g(k - S + 1);
      3'd3: return m_en;
      3'd4: return m_mode;
      3'd5: return m_status;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_mode = '0; m_status = '0;
    k = 0;
    hist.delete();
  endtask

  task automatic step(input logic w, input logic [2:0] a, input logic [W-1:0] d);
    logic [W-1:0] di, pv, e;
    if (reset_n) begin
      k++;
      hist.push_back(gpio_in);
      di = g(k - S);
      pv = g(k - S - 1);
      e = (k >= S + 2) ? ((m_mode & di & ~pv) | (~m_mode & ~di & pv)) : '0;
      m_status = (m_status & ~((w && a == 3'd5) ? d : '0)) | e;
      if (w)
        case (a)
          3'd0: m_out = d;
          3'd1: m_dir = d;
          3'd3: m_en = d;
          3'd4: m_mode = d;
          3'd6: m_out = m_out | d;
          3'd7: m_out = m_out & ~d;
          default: ;
        endcase
    end
    @(posedge clk);
    #1;
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    chk("irq", 32'(irq), 32'(|(m_status & m_en)));
  endtask

  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    exp = 32'(mread(a));
    bus_req = 1; bus_we = we; bus_addr = a; bus_wdata = d;
    step(we, a, d[W-1:0]);
    rd = bus_rdata;
    chk("ack_high", 32'(bus_ack), 1);
    if (!we) chk("rdata", bus_rdata, exp);
    bus_req = 0;
    step(0, 0, 0);
    chk("ack_low", 32'(bus_ack), 0);
    chk("rdata_idle", bus_rdata, 0);
    step(0, 0, 0);
  endtask

  initial begin
    int acks;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(gpio_out), 0);
    chk("rst_oe", 32'(gpio_oe), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_rdata", bus_rdata, 0);
    reset_n = 1;
    bus(1, 1, 32'hFF, r);
    chk("oe_ff", 32'(gpio_oe), 32'hFF);
    bus(1, 0, 32'hA5, r);
    chk("out_a5", 32'(gpio_out), 32'hA5);
    bus(0, 0, 0, r);
    chk("read_a5", r, 32'h0000_00A5);
    bus(1, 0, 32'hA0, r);
    bus(1, 6, 32'h0F, r);
    chk("set_af", 32'(gpio_out), 32'hAF);
    bus(1, 7, 32'h81, r);
    chk("clr_2e", 32'(gpio_out), 32'h2E);
    bus(0, 6, 0, r);
    chk("read_set", r, 0);
    bus(0, 7, 0, r);
    chk("read_clr", r, 0);
    bus(1, 4, 32'h08, r);
    bus(1, 3, 32'h08, r);
    gpio_in[3] = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    bus(0, 2, 0, r);
    chk("data_in3", 32'(r[3]), 1);
    bus(0, 5, 0, r);
    chk("status_08", r, 32'h08);
    chk("irq_set", 32'(irq), 1);
    bus(1, 5, 32'h08, r);
    chk("irq_w1c", 32'(irq), 0);
    gpio_in[3] = 0;
    repeat (4) step(0, 0, 0);
    gpio_in[3] = 1;
    repeat (4) step(0, 0, 0);
    gpio_in[3] = 0;
    repeat (4) step(0, 0, 0);
    gpio_in[3] = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    bus(1, 5, 32'h08, r);
    chk("set_wins_irq", 32'(irq), 1);
    bus(0, 5, 0, r);
    chk("set_wins_status", r, 32'h08);
    bus(1, 2, 32'h55, r);
    bus(0, 2, 0, r);
    bus_req = 1; bus_we = 0; bus_addr = 3'd1;
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0);
      if (bus_ack) acks++;
    end
    chk("held_acks", 32'(acks), 3);
    bus_req = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) gpio_in = W'($urandom);
      case ($urandom_range(2))
        0: step(0, 0, 0);
        1: bus(1, 3'($urandom_range(7)), $urandom, r);
        default: bus(0, 3'($urandom_range(7)), 0, r);
      endcase
    end
    bus_req = 1; bus_we = 1; bus_addr = 3'd0; bus_wdata = 32'h3C;
    step(1, 0, 8'h3C);
    gpio_in = 8'h81;
    reset_n = 0;
    bus_req = 0;
    model_reset();
    #1;
    chk("rst_mid_ack", 32'(bus_ack), 0);
    chk("rst_mid_out", 32'(gpio_out), 0);
    repeat (2) step(0, 0, 0);
    reset_n = 1;
    bus(1, 4, 32'hFF, r);
    bus(1, 3, 32'hFF, r);
    repeat (6) step(0, 0, 0);
    bus(0, 5, 0, r);
    chk("no_spurious", r, 0);
    chk("no_spurious_irq", 32'(irq), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
